// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serial frame transmitter for the one-bit "11" detector link.
// Accepts a parallel word over valid/ready and emits PRE_PAT (MSB-first),
// then the payload MSB-first, then GAP_LEN idle zeros.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN adds one even-parity bit
// after the payload (PAR state). Without it there is no parity logic at all.
//
// Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE, so tx_valid/tx_data are ignored elsewhere.
// All outputs are flops fed from the next-state values, so they change
// exactly at the edge that enters a state.
module serial_frame_tx #(
    parameter int                   DATA_W  = 8,
    parameter int                   PRE_LEN = 2,
    parameter logic [PRE_LEN-1:0]   PRE_PAT = 2'b11,
    parameter int                   GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_A   = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
    localparam int MAX_LEN = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;
    localparam int FRAME_W = PRE_LEN + DATA_W;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_GAP  = 3'd4
    } state_t;
`endif

    // Current state is kept as a named register so checkers can bind to it.
    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    // Marker and payload share one shift register: its MSB is the line bit
    // throughout PRE and DATA, so no variable indexing is needed.
    logic [FRAME_W-1:0]  shreg, shreg_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                parity, parity_d;
`endif

    logic tx_ready_d, out_bit_d, out_valid_d, busy_d, frame_done_d;

    // State register: sequencing state, bit counter and frame shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            shreg <= shreg_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity <= parity_d;
`endif
        end
    end

    // Next-state logic: walk IDLE -> PRE -> DATA -> [PAR] -> GAP -> IDLE.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d = parity;
`endif
        case (state)
            ST_IDLE: begin
                // tx_ready is high whenever the state is IDLE.
                if (tx_valid) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                    shreg_d = {PRE_PAT, tx_data};
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            ST_PRE: begin
                shreg_d = shreg << 1;
                if (cnt == PRE_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                shreg_d = shreg << 1;
                if (cnt == DATA_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_GAP;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            ST_PAR: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
`endif
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so the flops below hold the values
    // that belong to the state being entered.
    always_comb begin
        tx_ready_d   = 1'b0;
        busy_d       = 1'b1;
        out_valid_d  = 1'b0;
        out_bit_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            ST_PRE, ST_DATA: begin
                out_valid_d = 1'b1;
                out_bit_d   = shreg_d[FRAME_W-1];
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            ST_PAR: begin
                out_valid_d = 1'b1;
                out_bit_d   = parity_d;
            end
`endif
            ST_GAP: begin
                // Pulse only on entry into GAP, where the counter restarts.
                frame_done_d = (cnt_d == '0);
            end
            default: begin
                tx_ready_d = 1'b0;
            end
        endcase
    end

    // Output register: every port is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ready   <= 1'b1;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_ready   <= tx_ready_d;
            out_bit    <= out_bit_d;
            out_valid  <= out_valid_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for serial_frame_tx with default
// parameters. Expected line bits are queued when a word is offered and
// popped whenever the transmitter marks a bit valid.
module tb_serial_frame_tx;

    localparam int DATA_W  = 8;
    localparam int PRE_LEN = 2;
    localparam logic [PRE_LEN-1:0] PRE_PAT = 2'b11;
    localparam int GAP_LEN = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FL     = PRE_LEN + DATA_W + PAR_BITS;
    localparam int PERIOD = 1 + FL + GAP_LEN;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready, out_bit, out_valid, busy, frame_done;

    always #5 clk = ~clk;

    serial_frame_tx #(
        .DATA_W (DATA_W),
        .PRE_LEN(PRE_LEN),
        .PRE_PAT(PRE_PAT),
        .GAP_LEN(GAP_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // ---------------- scoreboard state ----------------
    logic [0:0] exp_q[$];
    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    int cyc      = 0;
    int hs_prev  = 0;
    int hs_last  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d);
        logic [PRE_LEN-1:0] pat;
        pat = PRE_PAT;
        for (int i = PRE_LEN - 1; i >= 0; i--) exp_q.push_back(pat[i]);
        for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Line monitor: every valid bit must match the head of the queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("bit_unexpected", {31'd0, out_bit}, 32'hFFFF_FFFF);
            end else begin
                chk("line_bit", {31'd0, out_bit}, {31'd0, exp_q.pop_front()});
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            chk("done_while_valid", {31'd0, out_valid}, 32'd0);
        end
    end

    // Handshake timestamps, judged from the bench's view of the port.
    always @(posedge clk) begin
        cyc++;
        if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            hs_cnt++;
            hs_prev = hs_last;
            hs_last = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int n = 0; n < 60; n++) begin
            if (tx_ready === 1'b1 && busy === 1'b0) begin
                ok = 1;
                break;
            end
            step();
        end
        chk("idle_timeout", ok, 32'd1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        push_frame(d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [FL-1:0] a5_bits;
        int            base_hs, base_done;

`ifdef SERIAL_FRAME_TX_PARITY_EN
        a5_bits = {10'b1110100101, 1'b0};
`else
        a5_bits = 10'b1110100101;
`endif
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        step();
        step();
        chk("rst_tx_ready",   {31'd0, tx_ready},   32'd1);
        chk("rst_out_bit",    {31'd0, out_bit},    32'd0);
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        step();

        // Cycle-exact frame for 8'hA5.
        base_done = done_cnt;
        send(8'hA5);
        for (int i = 0; i < FL; i++) begin
            chk("a5_valid", {31'd0, out_valid}, 32'd1);
            chk("a5_bit",   {31'd0, out_bit},   {31'd0, a5_bits[FL-1-i]});
            chk("a5_ready", {31'd0, tx_ready},  32'd0);
            step();
        end
        chk("a5_gap1_valid", {31'd0, out_valid},  32'd0);
        chk("a5_gap1_bit",   {31'd0, out_bit},    32'd0);
        chk("a5_gap1_done",  {31'd0, frame_done}, 32'd1);
        chk("a5_gap1_busy",  {31'd0, busy},       32'd1);
        step();
        chk("a5_gap2_valid", {31'd0, out_valid},  32'd0);
        chk("a5_gap2_done",  {31'd0, frame_done}, 32'd0);
        chk("a5_gap2_ready", {31'd0, tx_ready},   32'd0);
        step();
        chk("a5_ready_back", {31'd0, tx_ready},   32'd1);
        chk("a5_busy_back",  {31'd0, busy},       32'd0);
        chk("a5_q_empty",    exp_q.size(),        32'd0);
        chk("a5_done_count", done_cnt - base_done, 32'd1);

        // Held tx_valid: two frames back-to-back at the minimum period.
        base_hs   = hs_cnt;
        base_done = done_cnt;
        push_frame(8'h3C);
        push_frame(8'hC3);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        for (int n = 0; n < 40 && hs_cnt != base_hs + 1; n++) step();
        tx_data = 8'hC3;
        for (int n = 0; n < 40 && hs_cnt != base_hs + 2; n++) step();
        tx_valid = 1'b0;
        chk("held_hs_count",  hs_cnt - base_hs,   32'd2);
        chk("held_hs_period", hs_last - hs_prev,  PERIOD);
        wait_idle();
        chk("held_q_empty",   exp_q.size(),        32'd0);
        chk("held_done",      done_cnt - base_done, 32'd2);

        // tx_valid pulsed with 8'hFF during DATA is ignored.
        base_hs   = hs_cnt;
        base_done = done_cnt;
        send(8'h5A);
        for (int n = 0; n < PRE_LEN + 1; n++) step();
        chk("ff_in_data_ready", {31'd0, tx_ready}, 32'd0);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        step();
        step();
        tx_valid = 1'b0;
        wait_idle();
        for (int n = 0; n < PERIOD; n++) step();
        chk("ff_hs_count", hs_cnt - base_hs,     32'd1);
        chk("ff_q_empty",  exp_q.size(),         32'd0);
        chk("ff_done",     done_cnt - base_done, 32'd1);

        // tx_valid together with reset: reset wins, no frame.
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        step();
        reset    = 1'b0;
        tx_valid = 1'b0;
        chk("rstv_busy",  {31'd0, busy},     32'd0);
        chk("rstv_ready", {31'd0, tx_ready}, 32'd1);
        for (int n = 0; n < 4; n++) step();
        chk("rstv_valid", {31'd0, out_valid}, 32'd0);

        // Reset during the 4th DATA bit aborts the frame without frame_done.
        base_done = done_cnt;
        send(8'h96);                  // now in cycle k+1
        for (int n = 0; n < PRE_LEN + 3; n++) step();   // cycle k+6
        chk("abort_valid_before", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        step();                       // cycle k+7
        reset = 1'b0;
        chk("abort_valid", {31'd0, out_valid},  32'd0);
        chk("abort_busy",  {31'd0, busy},       32'd0);
        chk("abort_ready", {31'd0, tx_ready},   32'd1);
        chk("abort_done",  {31'd0, frame_done}, 32'd0);
        exp_q.delete();
        send(8'h69);
        wait_idle();
        step();
        chk("abort_q_empty", exp_q.size(),         32'd0);
        chk("abort_done_cnt", done_cnt - base_done, 32'd1);

        // Parity corner words and a few random payloads.
        send(8'h01);
        wait_idle();
        send(8'h00);
        wait_idle();
        for (int r = 0; r < 4; r++) begin
            send(DATA_W'($urandom_range(0, 255)));
            wait_idle();
        end
        step();
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
